cnn_layer_accel_trans_sync_fifo: RTL and testbench

Single-clock, parametrised transaction FIFO that stores a metadata word and its payload word as one atomic entry, so metadata and payload can never drift apart. It presents a first-word-fall-through read port and adds occupancy count, almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags. It sits between the transaction ingress logic and the layer-accelerator input sequencer, in designs where both run on one clock.

---
 rtl/cnn_layer_accel_trans_fifo_pkg.sv | 21 ++
 rtl/cnn_layer_accel_trans_fifo_ram.sv | 34 +++
 rtl/cnn_layer_accel_trans_sync_fifo.sv | 150 +++++++++++++++
 tb/tb_cnn_layer_accel_trans_sync_fifo.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_layer_accel_trans_fifo_pkg.sv
// Shared definitions for the transaction FIFO: default field widths, the
// atomic {meta, pyld} entry layout and the occupancy threshold helpers.
package cnn_layer_accel_trans_fifo_pkg;

    localparam int META_WTH_DEF = 64;
    localparam int PYLD_WTH_DEF = 1024;

    typedef struct packed {
        logic [META_WTH_DEF-1:0] meta;
        logic [PYLD_WTH_DEF-1:0] pyld;
    } trans_entry_t;

    function automatic logic cnt_ge(input int cnt, input int thresh);
        return (cnt >= thresh);
    endfunction

    function automatic logic cnt_le(input int cnt, input int thresh);
        return (cnt <= thresh);
    endfunction

endpackage

// File: rtl/cnn_layer_accel_trans_fifo_ram.sv
// Simple dual-port storage for FIFO entries: one write port, one registered
// read port, no reset so it maps onto block RAM.
module cnn_layer_accel_trans_fifo_ram #(
    parameter int WTH   = 1088,
    parameter int DEPTH = 512,
    parameter int AWTH  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [AWTH-1:0] i_waddr,
    input  logic [WTH-1:0]  i_wdata,
    input  logic            i_re,
    input  logic [AWTH-1:0] i_raddr,
    output logic [WTH-1:0]  o_rdata
);

    logic [WTH-1:0] r_mem [DEPTH];
    logic [WTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cnn_layer_accel_trans_sync_fifo.sv
// Single-clock transaction FIFO: metadata and payload share one RAM word,
// read side is first-word-fall-through via a two-entry prefetch stage.
module cnn_layer_accel_trans_sync_fifo
    import cnn_layer_accel_trans_fifo_pkg::*;
#(
    parameter int META_WTH      = META_WTH_DEF,
    parameter int PYLD_WTH      = PYLD_WTH_DEF,
    parameter int DEPTH         = 512,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4,
    parameter int CNT_WTH       = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                err_clr,
    input  logic [META_WTH-1:0] meta_din,
    input  logic [PYLD_WTH-1:0] pyld_din,
    input  logic                wr_en,
    input  logic                rd_en,
    output logic [META_WTH-1:0] meta_dout,
    output logic [PYLD_WTH-1:0] pyld_dout,
    output logic                valid,
    output logic                empty,
    output logic                full,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [CNT_WTH-1:0]  count,
    output logic                overflow,
    output logic                underflow
);

    localparam int PTR_WTH = $clog2(DEPTH);
    localparam int ENT_WTH = META_WTH + PYLD_WTH;

    logic [PTR_WTH-1:0] r_wptr, r_rptr;
    logic [CNT_WTH-1:0] r_count, r_ram_cnt;
    logic               r_rd_vld, r_head_vld, r_skid_vld;
    logic [ENT_WTH-1:0] r_head, r_skid;
    logic               r_ovf, r_udf;

    logic [ENT_WTH-1:0] w_ram_q, w_nxt_head, w_nxt_skid;
    logic               w_nxt_head_vld, w_nxt_skid_vld;
    logic               w_full, w_push, w_pop, w_issue;
    logic [1:0]         w_occ;

    assign w_full = (r_count == CNT_WTH'(DEPTH));
    assign w_push = wr_en & ~w_full & ~flush;
    assign w_pop  = rd_en & r_head_vld & ~flush;

    // Entries held or in flight after this pop; a new read may only be
    // issued if the stage can still absorb it when it lands next cycle.
    assign w_occ   = 2'(r_head_vld) + 2'(r_skid_vld) + 2'(r_rd_vld) - 2'(w_pop);
    assign w_issue = (r_ram_cnt != '0) & (w_occ <= 2'd1) & ~flush;

    cnn_layer_accel_trans_fifo_ram #(
        .WTH   (ENT_WTH),
        .DEPTH (DEPTH),
        .AWTH  (PTR_WTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata ({meta_din, pyld_din}),
        .i_re    (w_issue),
        .i_raddr (r_rptr),
        .o_rdata (w_ram_q)
    );

    always_comb begin
        w_nxt_head     = r_head;
        w_nxt_head_vld = r_head_vld;
        w_nxt_skid     = r_skid;
        w_nxt_skid_vld = r_skid_vld;
        if (w_pop) begin
            w_nxt_head     = r_skid;
            w_nxt_head_vld = r_skid_vld;
            w_nxt_skid_vld = 1'b0;
        end
        if (r_rd_vld) begin
            if (!w_nxt_head_vld) begin
                w_nxt_head     = w_ram_q;
                w_nxt_head_vld = 1'b1;
            end else begin
                w_nxt_skid     = w_ram_q;
                w_nxt_skid_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ram_cnt  <= '0;
            r_rd_vld   <= 1'b0;
            r_head_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ram_cnt  <= '0;
            r_rd_vld   <= 1'b0;
            r_head_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_WTH'(1);
            end
            if (w_issue) begin
                r_rptr <= r_rptr + PTR_WTH'(1);
            end
            r_count    <= r_count + CNT_WTH'(w_push) - CNT_WTH'(w_pop);
            r_ram_cnt  <= r_ram_cnt + CNT_WTH'(w_push) - CNT_WTH'(w_issue);
            r_rd_vld   <= w_issue;
            r_head_vld <= w_nxt_head_vld;
            r_skid_vld <= w_nxt_skid_vld;
        end
    end

    always_ff @(posedge clk) begin
        r_head <= w_nxt_head;
        r_skid <= w_nxt_skid;
    end

    // Sticky errors: a new event in the err_clr cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (wr_en & w_full & ~flush) | (r_ovf & ~err_clr);
            r_udf <= (rd_en & ~r_head_vld & ~flush) | (r_udf & ~err_clr);
        end
    end

    assign meta_dout    = r_head_vld ? r_head[ENT_WTH-1 -: META_WTH] : '0;
    assign pyld_dout    = r_head_vld ? r_head[PYLD_WTH-1:0] : '0;
    assign valid        = r_head_vld;
    assign empty        = ~r_head_vld;
    assign full         = w_full;
    assign almost_full  = cnt_ge(32'(r_count), AFULL_THRESH);
    assign almost_empty = cnt_le(32'(r_count), AEMPTY_THRESH);
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule

// File: tb/tb_cnn_layer_accel_trans_sync_fifo.sv
// Directed bench for the transaction FIFO: a vector table for short
// sequences plus hand-written fill, streaming, flush and reset scenarios.
module tb_cnn_layer_accel_trans_sync_fifo;

    localparam int MW = 64;
    localparam int PW = 1024;
    localparam int DP = 512;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          err_clr = 1'b0;
    logic [MW-1:0] meta_din = '0;
    logic [PW-1:0] pyld_din = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [MW-1:0] meta_dout;
    logic [PW-1:0] pyld_dout;
    logic          valid, empty, full, almost_full, almost_empty;
    logic [CW-1:0] count;
    logic          overflow, underflow;

    int total = 0;
    int bad   = 0;

    cnn_layer_accel_trans_sync_fifo #(
        .META_WTH (MW),
        .PYLD_WTH (PW),
        .DEPTH    (DP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .err_clr      (err_clr),
        .meta_din     (meta_din),
        .pyld_din     (pyld_din),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .meta_dout    (meta_dout),
        .pyld_dout    (pyld_dout),
        .valid        (valid),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr, rd, fl, ec;
        logic [MW-1:0] meta;
        logic [PW-1:0] pyld;
        logic          e_vld;
        int            e_cnt;
        logic [MW-1:0] e_meta;
        logic [PW-1:0] e_pyld;
        logic          e_ovf, e_udf;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [PW-1:0] mkp(input int v);
        return {32{v}};
    endfunction

    function automatic vec_t mkv(input logic wr, input logic rd, input logic fl,
                                 input logic ec, input int m, input logic e_vld,
                                 input int e_cnt, input int e_m,
                                 input logic e_ovf, input logic e_udf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.fl = fl; v.ec = ec;
        v.meta = 64'(m);
        v.pyld = mkp(m);
        v.e_vld = e_vld;
        v.e_cnt = e_cnt;
        v.e_meta = e_vld ? 64'(e_m) : 64'd0;
        v.e_pyld = e_vld ? mkp(e_m) : '0;
        v.e_ovf = e_ovf;
        v.e_udf = e_udf;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic chkp(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        logic [255:0] a_lo, e_lo;
        a_lo = act[255:0];
        e_lo = exp[255:0];
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s payload got(lo)=%0h want(lo)=%0h", nm, a_lo, e_lo);
        end
    endtask

    task automatic chk_state(input string nm, input int c, input logic v);
        chk({nm, ".count"}, 64'(count), 64'(c));
        chk({nm, ".valid"}, 64'(valid), 64'(v));
        chk({nm, ".empty"}, 64'(empty), 64'(!v));
        chk({nm, ".full"}, 64'(full), 64'(c == DP));
        chk({nm, ".afull"}, 64'(almost_full), 64'(c >= DP - 4));
        chk({nm, ".aempty"}, 64'(almost_empty), 64'(c <= 4));
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_flush();
        idle();
        flush = 1'b1; err_clr = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        int exp_r;
        int guard;
        int wcnt;
        int rcnt;

        tbl[0]  = mkv(1, 0, 0, 0, 'h11, 0, 1, 0,    0, 0);
        tbl[1]  = mkv(0, 0, 0, 0, 0,    0, 1, 0,    0, 0);
        tbl[2]  = mkv(0, 0, 0, 0, 0,    1, 1, 'h11, 0, 0);
        tbl[3]  = mkv(0, 1, 0, 0, 0,    0, 0, 0,    0, 0);
        tbl[4]  = mkv(0, 1, 0, 0, 0,    0, 0, 0,    0, 1);
        tbl[5]  = mkv(0, 0, 0, 1, 0,    0, 0, 0,    0, 0);
        tbl[6]  = mkv(0, 1, 0, 1, 0,    0, 0, 0,    0, 1);
        tbl[7]  = mkv(0, 0, 0, 1, 0,    0, 0, 0,    0, 0);
        tbl[8]  = mkv(1, 0, 0, 0, 'h22, 0, 1, 0,    0, 0);
        tbl[9]  = mkv(1, 0, 0, 0, 'h33, 0, 2, 0,    0, 0);
        tbl[10] = mkv(0, 0, 0, 0, 0,    1, 2, 'h22, 0, 0);
        tbl[11] = mkv(0, 1, 0, 0, 0,    1, 1, 'h33, 0, 0);
        tbl[12] = mkv(0, 1, 0, 0, 0,    0, 0, 0,    0, 0);
        // First entry uses the 0xAA byte pattern for the payload.
        tbl[0].pyld  = {128{8'hAA}};
        tbl[2].e_pyld = {128{8'hAA}};

        // Reset state
        tick(); tick();
        chk_state("rst_hold", 0, 0);
        chk("rst_hold.ovf", 64'(overflow), 64'd0);
        chk("rst_hold.udf", 64'(underflow), 64'd0);
        chk("rst_hold.meta", meta_dout, 64'd0);
        #2 rst_n = 1'b1;
        tick();
        chk_state("rst_rel", 0, 0);

        // Vector table
        for (int i = 0; i < 13; i++) begin
            wr_en = tbl[i].wr; rd_en = tbl[i].rd;
            flush = tbl[i].fl; err_clr = tbl[i].ec;
            meta_din = tbl[i].meta; pyld_din = tbl[i].pyld;
            tick();
            chk_state($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_vld);
            chk($sformatf("vec%0d.meta", i), meta_dout, tbl[i].e_meta);
            chkp($sformatf("vec%0d.pyld", i), pyld_dout, tbl[i].e_pyld);
            chk($sformatf("vec%0d.ovf", i), 64'(overflow), 64'(tbl[i].e_ovf));
            chk($sformatf("vec%0d.udf", i), 64'(underflow), 64'(tbl[i].e_udf));
        end
        idle();

        // Fill to full, overflow, refused push at full with pop, ordered drain
        do_flush();
        for (int i = 0; i < DP; i++) begin
            wr_en = 1'b1; meta_din = 64'(i); pyld_din = mkp(i);
            tick();
            chk($sformatf("fill%0d.count", i), 64'(count), 64'(i + 1));
            chk($sformatf("fill%0d.afull", i), 64'(almost_full), 64'(i + 1 >= DP - 4));
        end
        meta_din = 64'hDEAD; pyld_din = mkp('hDEAD);
        tick();
        chk_state("ovf_push", DP, 1);
        chk("ovf_push.ovf", 64'(overflow), 64'd1);
        chk("ovf_push.head", meta_dout, 64'd0);
        idle(); err_clr = 1'b1;
        tick();
        chk("ovf_clr.ovf", 64'(overflow), 64'd0);
        idle();
        wr_en = 1'b1; rd_en = 1'b1; meta_din = 64'hBEEF;
        tick();
        chk("full_wrrd.count", 64'(count), 64'(DP - 1));
        chk("full_wrrd.ovf", 64'(overflow), 64'd1);
        idle();
        exp_r = 1;
        guard = 0;
        while (valid && guard < 600) begin
            rd_en = 1'b1;
            chk($sformatf("drain%0d.meta", exp_r), meta_dout, 64'(exp_r));
            chkp($sformatf("drain%0d.pyld", exp_r), pyld_dout, mkp(exp_r));
            exp_r++;
            guard++;
            tick();
        end
        idle();
        chk("drain.words", 64'(exp_r), 64'(DP));
        chk_state("drain_end", 0, 0);

        // Back-to-back streaming with pointer wrap
        do_flush();
        wcnt = 0; rcnt = 0;
        for (int c = 0; c < 2000; c++) begin
            wr_en = 1'b1; meta_din = 64'(wcnt); pyld_din = mkp(wcnt);
            rd_en = valid;
            if (c >= 3) chk($sformatf("stream%0d.nobubble", c), 64'(valid), 64'd1);
            if (valid) begin
                chk($sformatf("stream%0d.meta", c), meta_dout, 64'(rcnt));
                chkp($sformatf("stream%0d.pyld", c), pyld_dout, mkp(rcnt));
                rcnt++;
            end
            wcnt++;
            tick();
        end
        wr_en = 1'b0;
        guard = 0;
        while ((valid || count != 0) && guard < 20) begin
            rd_en = valid;
            if (valid) begin
                chk($sformatf("sdrain%0d.meta", rcnt), meta_dout, 64'(rcnt));
                rcnt++;
            end
            guard++;
            tick();
        end
        idle();
        chk("stream.total", 64'(rcnt), 64'd2000);
        chk_state("stream_end", 0, 0);
        chk("stream.ovf", 64'(overflow), 64'd0);
        chk("stream.udf", 64'(underflow), 64'd0);

        // Flush mid-stream with simultaneous push and pop
        do_flush();
        for (int i = 0; i < 100; i++) begin
            wr_en = 1'b1; meta_din = 64'(1000 + i); pyld_din = mkp(1000 + i);
            tick();
        end
        idle();
        chk_state("pre_flush", 100, 1);
        wr_en = 1'b1; rd_en = 1'b1; flush = 1'b1; meta_din = 64'h999;
        tick();
        idle();
        chk_state("flush", 0, 0);
        chk("flush.ovf", 64'(overflow), 64'd0);
        chk("flush.udf", 64'(underflow), 64'd0);
        wr_en = 1'b1; meta_din = 64'h55; pyld_din = mkp('h55);
        tick();
        idle();
        chk_state("pflush_w1", 1, 0);
        tick();
        chk_state("pflush_w2", 1, 0);
        tick();
        chk_state("pflush_w3", 1, 1);
        chk("pflush.meta", meta_dout, 64'h55);

        // Asynchronous reset mid-burst
        do_flush();
        rd_en = 1'b1;
        tick();
        idle();
        chk("arst_pre.udf", 64'(underflow), 64'd1);
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; meta_din = 64'(200 + i); pyld_din = mkp(200 + i);
            tick();
        end
        chk("arst_pre.valid", 64'(valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_state("arst", 0, 0);
        chk("arst.ovf", 64'(overflow), 64'd0);
        chk("arst.udf", 64'(underflow), 64'd0);
        chk("arst.meta", meta_dout, 64'd0);
        chkp("arst.pyld", pyld_dout, '0);
        idle();
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk_state("arst_rel", 0, 0);
        wr_en = 1'b1; meta_din = 64'h77; pyld_din = mkp('h77);
        tick();
        idle();
        chk_state("arst_w1", 1, 0);
        tick();
        tick();
        chk_state("arst_w3", 1, 1);
        chk("arst_w3.meta", meta_dout, 64'h77);
        chkp("arst_w3.pyld", pyld_dout, mkp('h77));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
